// File: rtl/pwm_regs_pkg.sv
// Shared definitions for the PWM control-register arbiter.
//   - Default widths and register count
//   - Register address map (0x00..0x04)
//   - Arbiter FSM state and requester-id encodings
package pwm_regs_pkg;

  localparam int ADDR_W   = 7;
  localparam int DATA_W   = 8;
  localparam int NUM_REGS = 5;

  localparam logic [ADDR_W-1:0] ADDR_EN_LO  = 7'h00;
  localparam logic [ADDR_W-1:0] ADDR_EN_HI  = 7'h01;
  localparam logic [ADDR_W-1:0] ADDR_PWM_LO = 7'h02;
  localparam logic [ADDR_W-1:0] ADDR_PWM_HI = 7'h03;
  localparam logic [ADDR_W-1:0] ADDR_DUTY   = 7'h04;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_e;

  typedef enum logic {
    REQ_SPI = 1'b0,
    REQ_SEQ = 1'b1
  } req_id_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   valid_i[1:0]: request lines (bit 0 = SPI, bit 1 = sequencer)
//   advance_i   : grant is being taken this cycle; update the pointer
//   grant_o[1:0]: one-hot grant (all zero when nothing is valid)
// The pointer names the requester that wins the next contention; it
// resets to SPI and, after each grant, points at the other requester.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid_i,
  input  logic       advance_i,
  output logic [1:0] grant_o
);

  logic prio_q, prio_d;  // 0: SPI favoured, 1: sequencer favoured

  always_comb begin
    grant_o = 2'b00;
    case (valid_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = prio_q ? 2'b10 : 2'b01;
      default: grant_o = 2'b00;
    endcase
  end

  always_comb begin
    prio_d = prio_q;
    // SPI granted -> favour the sequencer next, and vice versa.
    if (advance_i && (grant_o != 2'b00)) prio_d = grant_o[0];
  end

  always_ff @(posedge clk) begin
    if (rst) prio_q <= 1'b0;
    else     prio_q <= prio_d;
  end

endmodule

// File: rtl/pwm_reg_arbiter.sv
// PWM control-register bank with a two-requester write arbiter.
// Requester 0 is the SPI write port, requester 1 the duty sequencer.
// Ports:
//   clk, rst                    : clock, synchronous active-high reset
//   spi_req_valid/addr/data     : SPI write request; spi_req_ready accepts it
//   seq_req_valid/addr/data     : sequencer write request; seq_req_ready accepts it
//   period_end                  : PWM counter wrap pulse (duty commit point)
//   en_out_lo/hi, pwm_en_lo/hi  : registers 0x00..0x03
//   pwm_duty                    : register 0x04, active duty
//   duty_pending                : shadow duty waiting for period_end
//   wr_err                      : one-cycle pulse when a granted write is dropped
//   dbg_state                   : current arbiter FSM state
// Handshake: a requester holds valid/addr/data until it sees ready; ready is
// high for exactly the IDLE cycle in which that request is latched (accept
// edge N), the write lands at edge N+1, so at most one write per two cycles.
// Build option PWM_DUTY_SHADOW_EN: duty writes go to a shadow register and
// commit to pwm_duty on period_end; without it duty writes apply directly.
module pwm_reg_arbiter #(
  parameter int ADDR_W   = pwm_regs_pkg::ADDR_W,
  parameter int DATA_W   = pwm_regs_pkg::DATA_W,
  parameter int NUM_REGS = pwm_regs_pkg::NUM_REGS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 spi_req_valid,
  input  logic [ADDR_W-1:0]    spi_req_addr,
  input  logic [DATA_W-1:0]    spi_req_data,
  output logic                 spi_req_ready,
  input  logic                 seq_req_valid,
  input  logic [ADDR_W-1:0]    seq_req_addr,
  input  logic [DATA_W-1:0]    seq_req_data,
  output logic                 seq_req_ready,
  input  logic                 period_end,
  output logic [DATA_W-1:0]    en_out_lo,
  output logic [DATA_W-1:0]    en_out_hi,
  output logic [DATA_W-1:0]    pwm_en_lo,
  output logic [DATA_W-1:0]    pwm_en_hi,
  output logic [DATA_W-1:0]    pwm_duty,
  output logic                 duty_pending,
  output logic                 wr_err,
  output pwm_regs_pkg::state_e dbg_state
);
  import pwm_regs_pkg::*;

  state_e            state_q, state_d;
  req_id_e           req_id_q, req_id_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [DATA_W-1:0] req_data_q, req_data_d;
  logic [DATA_W-1:0] en_lo_q, en_lo_d, en_hi_q, en_hi_d;
  logic [DATA_W-1:0] pwm_lo_q, pwm_lo_d, pwm_hi_q, pwm_hi_d;
  logic [DATA_W-1:0] duty_q, duty_d;
  logic              wr_err_q, wr_err_d;
  logic [1:0]        grant;
  logic              addr_bad, wr_ok;

  rr_arb2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .valid_i   ({seq_req_valid, spi_req_valid}),
    .advance_i (state_q == IDLE),
    .grant_o   (grant)
  );

  // FSM, request latch and ready generation.
  always_comb begin
    state_d       = state_q;
    req_id_d      = req_id_q;
    req_addr_d    = req_addr_q;
    req_data_d    = req_data_q;
    spi_req_ready = 1'b0;
    seq_req_ready = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant != 2'b00) begin
          spi_req_ready = grant[0] & ~rst;
          seq_req_ready = grant[1] & ~rst;
          req_id_d      = grant[1] ? REQ_SEQ : REQ_SPI;
          req_addr_d    = grant[1] ? seq_req_addr : spi_req_addr;
          req_data_d    = grant[1] ? seq_req_data : spi_req_data;
          state_d       = WRITE;
        end
      end
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The sequencer may only touch the duty register.
  assign addr_bad = (req_addr_q >= ADDR_W'(NUM_REGS)) ||
                    ((req_id_q == REQ_SEQ) && (req_addr_q != ADDR_W'(ADDR_DUTY)));
  assign wr_ok    = (state_q == WRITE) && !addr_bad;
  assign wr_err_d = (state_q == WRITE) && addr_bad;

`ifdef PWM_DUTY_SHADOW_EN
  logic [DATA_W-1:0] shadow_q, shadow_d;
  logic              pending_q, pending_d;
`else
  logic              unused_period_end;
  assign unused_period_end = period_end;
`endif

  always_comb begin
    en_lo_d  = en_lo_q;
    en_hi_d  = en_hi_q;
    pwm_lo_d = pwm_lo_q;
    pwm_hi_d = pwm_hi_q;
    duty_d   = duty_q;
`ifdef PWM_DUTY_SHADOW_EN
    shadow_d  = shadow_q;
    pending_d = pending_q;
    // Commit uses the shadow held before this cycle; a coincident duty
    // write below overrides shadow/pending afterwards.
    if (period_end && pending_q) begin
      duty_d    = shadow_q;
      pending_d = 1'b0;
    end
`endif
    if (wr_ok) begin
      case (req_addr_q)
        ADDR_EN_LO:  en_lo_d  = req_data_q;
        ADDR_EN_HI:  en_hi_d  = req_data_q;
        ADDR_PWM_LO: pwm_lo_d = req_data_q;
        ADDR_PWM_HI: pwm_hi_d = req_data_q;
        ADDR_DUTY: begin
`ifdef PWM_DUTY_SHADOW_EN
          shadow_d  = req_data_q;
          pending_d = 1'b1;
`else
          duty_d    = req_data_q;
`endif
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      req_id_q   <= REQ_SPI;
      req_addr_q <= '0;
      req_data_q <= '0;
      en_lo_q    <= '0;
      en_hi_q    <= '0;
      pwm_lo_q   <= '0;
      pwm_hi_q   <= '0;
      duty_q     <= '0;
      wr_err_q   <= 1'b0;
`ifdef PWM_DUTY_SHADOW_EN
      shadow_q   <= '0;
      pending_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      req_id_q   <= req_id_d;
      req_addr_q <= req_addr_d;
      req_data_q <= req_data_d;
      en_lo_q    <= en_lo_d;
      en_hi_q    <= en_hi_d;
      pwm_lo_q   <= pwm_lo_d;
      pwm_hi_q   <= pwm_hi_d;
      duty_q     <= duty_d;
      wr_err_q   <= wr_err_d;
`ifdef PWM_DUTY_SHADOW_EN
      shadow_q   <= shadow_d;
      pending_q  <= pending_d;
`endif
    end
  end

  assign en_out_lo = en_lo_q;
  assign en_out_hi = en_hi_q;
  assign pwm_en_lo = pwm_lo_q;
  assign pwm_en_hi = pwm_hi_q;
  assign pwm_duty  = duty_q;
  assign wr_err    = wr_err_q;
  assign dbg_state = state_q;
`ifdef PWM_DUTY_SHADOW_EN
  assign duty_pending = pending_q;
`else
  assign duty_pending = 1'b0;
`endif

endmodule

// File: tb/tb_pwm_reg_arbiter.sv
// Self-checking bench for pwm_reg_arbiter (honours PWM_DUTY_SHADOW_EN).
module tb_pwm_reg_arbiter;
  import pwm_regs_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       spi_req_valid = 1'b0, seq_req_valid = 1'b0;
  logic [6:0] spi_req_addr = '0, seq_req_addr = '0;
  logic [7:0] spi_req_data = '0, seq_req_data = '0;
  logic       spi_req_ready, seq_req_ready;
  logic       period_end = 1'b0;
  logic [7:0] en_out_lo, en_out_hi, pwm_en_lo, pwm_en_hi, pwm_duty;
  logic       duty_pending, wr_err;
  state_e     dbg_state;

  pwm_reg_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .spi_req_valid (spi_req_valid),
    .spi_req_addr  (spi_req_addr),
    .spi_req_data  (spi_req_data),
    .spi_req_ready (spi_req_ready),
    .seq_req_valid (seq_req_valid),
    .seq_req_addr  (seq_req_addr),
    .seq_req_data  (seq_req_data),
    .seq_req_ready (seq_req_ready),
    .period_end    (period_end),
    .en_out_lo     (en_out_lo),
    .en_out_hi     (en_out_hi),
    .pwm_en_lo     (pwm_en_lo),
    .pwm_en_hi     (pwm_en_hi),
    .pwm_duty      (pwm_duty),
    .duty_pending  (duty_pending),
    .wr_err        (wr_err),
    .dbg_state     (dbg_state)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / reference model ----------------
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  logic [7:0] m_reg[5];     // index = register address
  logic [7:0] m_shadow;
  bit         m_pending;
  int         m_last;       // requester granted most recently

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] dut_reg(input int i);
    case (i)
      0:       return en_out_lo;
      1:       return en_out_hi;
      2:       return pwm_en_lo;
      3:       return pwm_en_hi;
      default: return pwm_duty;
    endcase
  endfunction

  task automatic check_all(input string tag);
    for (int i = 0; i < 5; i++) chk($sformatf("%s reg%0d", tag, i), dut_reg(i), m_reg[i]);
    chk($sformatf("%s duty_pending", tag), duty_pending, m_pending);
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 5; i++) m_reg[i] = 8'h00;
    m_shadow  = 8'h00;
    m_pending = 1'b0;
    m_last    = 1;  // so the first contention goes to SPI
  endfunction

  function automatic void model_pe();
`ifdef PWM_DUTY_SHADOW_EN
    if (m_pending) begin
      m_reg[4]  = m_shadow;
      m_pending = 1'b0;
    end
`endif
  endfunction

  // Returns the expected wr_err for this write.
  function automatic bit model_write(input int id, input logic [6:0] addr,
                                     input logic [7:0] data, input bit pe);
    bit err;
    err    = (addr >= 7'd5) || (id == 1 && addr != 7'd4);
    m_last = id;
    if (pe) model_pe();
    if (!err) begin
`ifdef PWM_DUTY_SHADOW_EN
      if (addr == 7'd4) begin
        m_shadow  = data;
        m_pending = 1'b1;
      end else m_reg[addr] = data;
`else
      m_reg[addr] = data;
`endif
    end
    return err;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input int id, input bit v, input logic [6:0] a, input logic [7:0] d);
    if (id == 0) begin
      spi_req_valid = v; spi_req_addr = a; spi_req_data = d;
    end else begin
      seq_req_valid = v; seq_req_addr = a; seq_req_data = d;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0);
    drive(1, 0, 0, 0);
    period_end = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  // Returns at the negedge of the cycle in which ready is seen.
  task automatic wait_grant(input int exp_id);
    bit ok = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (spi_req_ready || seq_req_ready) begin
        chk("grant id", {31'd0, seq_req_ready}, exp_id);
        chk("single ready", {31'd0, spi_req_ready & seq_req_ready}, 0);
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL grant timeout: no ready, expected requester %0d", exp_id);
    end
  endtask

  // Finishes the accepted request of requester id; returns #1 after the
  // write edge with the model updated and expected wr_err in err.
  task automatic finish_write(input int id, input logic [6:0] a, input logic [7:0] d,
                              input bit pe_in_write, output bit err);
    @(posedge clk);
    #1 drive(id, 0, 0, 0);
    chk("ready low in WRITE", {30'd0, spi_req_ready, seq_req_ready}, 0);
    if (pe_in_write) period_end = 1'b1;
    @(posedge clk);
    #1 period_end = 1'b0;
    err = model_write(id, a, d, pe_in_write);
  endtask

  task automatic single_write(input int id, input logic [6:0] a, input logic [7:0] d,
                              input bit pe_in_write, output bit err);
    drive(id, 1, a, d);
    wait_grant(id);
    finish_write(id, a, d, pe_in_write, err);
  endtask

  task automatic pulse_pe();
    period_end = 1'b1;
    @(posedge clk);
    #1 period_end = 1'b0;
    model_pe();
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    int         id;
    logic [6:0] addr;
    logic [7:0] data;
    bit         err;
    int         ridx;
    logic [7:0] rval;
  } vec_t;

  vec_t tbl[8];

  initial begin
    bit e;
    logic [6:0] a0, a1;
    logic [7:0] d0, d1;
    int id, win, los;

    tbl[0] = '{0, 7'h00, 8'hA5, 1'b0, 0, 8'hA5};
    tbl[1] = '{0, 7'h01, 8'h3C, 1'b0, 1, 8'h3C};
    tbl[2] = '{0, 7'h02, 8'h0F, 1'b0, 2, 8'h0F};
    tbl[3] = '{1, 7'h01, 8'hFF, 1'b1, 1, 8'h3C};
    tbl[4] = '{0, 7'h07, 8'h11, 1'b1, 0, 8'hA5};
    tbl[5] = '{0, 7'h03, 8'h55, 1'b0, 3, 8'h55};
    tbl[6] = '{1, 7'h7F, 8'h22, 1'b1, 3, 8'h55};
    tbl[7] = '{0, 7'h05, 8'h99, 1'b1, 2, 8'h0F};

    // Reset state
    do_reset();
    check_all("reset");
    chk("reset wr_err", wr_err, 0);
    chk("reset state", dbg_state, IDLE);
    chk("reset ready", {30'd0, spi_req_ready, seq_req_ready}, 0);

    // Table of single writes
    for (int i = 0; i < 8; i++) begin
      single_write(tbl[i].id, tbl[i].addr, tbl[i].data, 1'b0, e);
      chk($sformatf("tbl%0d wr_err", i), wr_err, tbl[i].err);
      chk($sformatf("tbl%0d reg", i), dut_reg(tbl[i].ridx), tbl[i].rval);
      @(posedge clk);
      #1 chk($sformatf("tbl%0d wr_err pulse end", i), wr_err, 0);
    end
    check_all("table");

    // Continuous contention: grants SPI, SEQ, SPI two cycles apart
    do_reset();
    exp_q = {8'd1, 8'd0, 8'd2, 8'd0, 8'd1, 8'd0};
    drive(0, 1, 7'h02, 8'h0F);
    drive(1, 1, 7'h04, 8'h80);
    for (int c = 0; c < 6; c++) begin
      logic [7:0] exp_code;
      @(negedge clk);
      exp_code = exp_q.pop_front();
      chk($sformatf("contention cyc%0d ready", c), {30'd0, seq_req_ready, spi_req_ready}, exp_code);
    end
    @(posedge clk);
    #1 drive(0, 0, 0, 0);
    drive(1, 0, 0, 0);
    void'(model_write(0, 7'h02, 8'h0F, 1'b0));
    void'(model_write(1, 7'h04, 8'h80, 1'b0));
    void'(model_write(0, 7'h02, 8'h0F, 1'b0));
    check_all("contention");

    // Duty write and period_end commit
    do_reset();
    single_write(1, 7'h04, 8'h40, 1'b0, e);
    chk("duty wr_err", wr_err, 0);
`ifdef PWM_DUTY_SHADOW_EN
    chk("duty before pe", pwm_duty, 8'h00);
    chk("pending before pe", duty_pending, 1);
`else
    chk("duty direct", pwm_duty, 8'h40);
    chk("pending tied low", duty_pending, 0);
`endif
    pulse_pe();
    chk("duty after pe", pwm_duty, 8'h40);
    chk("pending after pe", duty_pending, 0);
    pulse_pe();
    chk("idle pe keeps duty", pwm_duty, 8'h40);

    // Duty write coincident with period_end, 0x30 already pending
    single_write(1, 7'h04, 8'h30, 1'b0, e);
    single_write(1, 7'h04, 8'h90, 1'b1, e);
`ifdef PWM_DUTY_SHADOW_EN
    chk("coincident duty", pwm_duty, 8'h30);
    chk("coincident pending", duty_pending, 1);
`else
    chk("coincident duty", pwm_duty, 8'h90);
    chk("coincident pending", duty_pending, 0);
`endif
    pulse_pe();
    chk("duty after 2nd pe", pwm_duty, 8'h90);
    chk("pending after 2nd pe", duty_pending, 0);
    check_all("duty");

    // Reset during WRITE discards the write
    do_reset();
    drive(0, 1, 7'h03, 8'h55);
    wait_grant(0);
    @(posedge clk);
    #1 drive(0, 0, 0, 0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    chk("rst-mid pwm_en_hi", pwm_en_hi, 8'h00);
    chk("rst-mid state", dbg_state, IDLE);
    chk("rst-mid ready", {30'd0, spi_req_ready, seq_req_ready}, 0);
    check_all("rst-mid");

    // Randomized traffic against the reference model
    do_reset();
    for (int it = 0; it < 80; it++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 2) begin
        pulse_pe();
        check_all($sformatf("rnd%0d pe", it));
      end else if (r < 4) begin
        a0 = ($urandom_range(0, 9) < 8) ? 7'($urandom_range(0, 4)) : 7'($urandom_range(5, 127));
        a1 = ($urandom_range(0, 1) == 1) ? 7'h04 : 7'($urandom_range(0, 127));
        d0 = 8'($urandom);
        d1 = 8'($urandom);
        win = (m_last == 0) ? 1 : 0;
        los = 1 - win;
        drive(0, 1, a0, d0);
        drive(1, 1, a1, d1);
        wait_grant(win);
        finish_write(win, win ? a1 : a0, win ? d1 : d0, 1'b0, e);
        chk($sformatf("rnd%0d win wr_err", it), wr_err, e);
        check_all($sformatf("rnd%0d win", it));
        wait_grant(los);
        finish_write(los, los ? a1 : a0, los ? d1 : d0, 1'b0, e);
        chk($sformatf("rnd%0d lose wr_err", it), wr_err, e);
        check_all($sformatf("rnd%0d lose", it));
      end else begin
        id = $urandom_range(0, 1);
        a0 = ($urandom_range(0, 9) < 8) ? 7'($urandom_range(0, 4)) : 7'($urandom_range(5, 127));
        if (id == 1 && $urandom_range(0, 2) != 0) a0 = 7'h04;
        d0 = 8'($urandom);
        single_write(id, a0, d0, ($urandom_range(0, 3) == 0), e);
        chk($sformatf("rnd%0d wr_err", it), wr_err, e);
        check_all($sformatf("rnd%0d", it));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_reg_arbiter.md
Name: pwm_reg_arbiter

Overview:
- Arbitrates register writes from two requesters into the PWM peripheral's control register bank.
  - Requester 0 is the SPI peripheral write port.
  - Requester 1 is the on-chip duty sequencer (fade engine).
- Owns the five control registers that drive the output-enable and PWM datapath.
- Duty updates are optionally shadowed so they apply only at a PWM period boundary, which avoids glitched pulses.

Parameters:
- ADDR_W, 7, register address width.
- DATA_W, 8, register data width.
- NUM_REGS, 5, number of implemented addresses (0x00..0x04).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- spi_req_valid  in  1  SPI write request.
- spi_req_addr  in  ADDR_W  SPI target address.
- spi_req_data  in  DATA_W  SPI write data.
- spi_req_ready  out  1  SPI request accepted this cycle.
- seq_req_valid  in  1  sequencer write request.
- seq_req_addr  in  ADDR_W  sequencer target address.
- seq_req_data  in  DATA_W  sequencer write data.
- seq_req_ready  out  1  sequencer request accepted this cycle.
- period_end  in  1  one-cycle pulse from the PWM counter at wrap.
- en_out_lo  out  8  register 0x00, output enable [7:0].
- en_out_hi  out  8  register 0x01, output enable [15:8].
- pwm_en_lo  out  8  register 0x02, PWM mode [7:0].
- pwm_en_hi  out  8  register 0x03, PWM mode [15:8].
- pwm_duty  out  8  register 0x04, active duty cycle.
- duty_pending  out  1  shadow duty is waiting for period_end.
- wr_err  out  1  one-cycle pulse when a granted write is dropped.

Behaviour:
- Reset (rst=1 at a clock edge):
  - All registers, shadow, duty_pending, wr_err, both ready outputs and the round-robin pointer go to 0.
  - FSM goes to IDLE.
  - Reset mid-WRITE discards the in-flight write.
- FSM states are IDLE and WRITE.
- IDLE:
  - If any valid is high, grant one requester.
  - Assert that requester's ready for exactly this cycle.
  - Latch its addr/data into the request registers, then go to WRITE.
  - Otherwise stay in IDLE; both ready outputs are 0.
- Arbitration:
  - One requester valid: it wins.
  - Both valid: the requester not granted last wins (round-robin).
  - The pointer updates on every grant; the first contention after reset goes to SPI.
- WRITE: perform the latched write, then return to IDLE unconditionally.
  - Both ready outputs are 0 in WRITE.
  - Throughput is one write per 2 cycles.
- Latency:
  - Accepted at edge N.
  - Write performed at edge N+1.
  - Non-duty register visible on its output after edge N+1.
- Requesters hold valid/addr/data stable until ready is seen.
  - Deasserting valid before ready is permitted; nothing is latched.
- Address decode (performed in WRITE):
  - addr ≥ NUM_REGS: write dropped, wr_err=1 for one cycle.
  - Sequencer writing any address other than 0x04: dropped, wr_err=1.
  - SPI may write all five registers.
- Duty write with shadowing:
  - Data goes to the shadow register and duty_pending is set.
  - On period_end with duty_pending=1: pwm_duty ← shadow, duty_pending cleared.
  - period_end with duty_pending=0: no effect.
- Duty write in the same cycle as period_end:
  - The commit uses the shadow value held before this cycle, if one was pending.
  - The new data lands in the shadow and duty_pending stays 1.
- Back-to-back duty writes before period_end: the last write wins.
- Writes to registers 0x00..0x03 ignore period_end entirely.

Optional Feature:
- Macro: PWM_DUTY_SHADOW_EN.
- Defined: shadow register and duty_pending behave as described under Behaviour.
- Undefined:
  - Duty writes update pwm_duty directly in WRITE, like the other registers.
  - duty_pending is tied to 0.
  - period_end is ignored.

Decomposition:
- Package pwm_regs_pkg:
  - ADDR_W, DATA_W and NUM_REGS defaults.
  - Register address constants: ADDR_EN_LO=0x00, ADDR_EN_HI=0x01, ADDR_PWM_LO=0x02, ADDR_PWM_HI=0x03, ADDR_DUTY=0x04.
  - FSM state enum {IDLE, WRITE}.
  - Requester-id typedef {REQ_SPI, REQ_SEQ}.
- Sub-module rr_arb2:
  - Two-input round-robin arbiter: valid[1:0] and an advance strobe in, one-hot grant out.
  - Holds the pointer; resets to favour REQ_SPI.

Test Plan:
- Reset, then SPI writes 0x00←0xA5 → spi_req_ready high one cycle; en_out_lo=0xA5 two edges after valid rose; wr_err stays 0.
- SPI and sequencer both valid continuously (SPI 0x02←0x0F, seq 0x04←0x80) → grants alternate SPI, SEQ, SPI; each ready high in alternate accept cycles 2 cycles apart.
- With PWM_DUTY_SHADOW_EN, seq writes 0x04←0x40 → pwm_duty stays 0x00 and duty_pending=1; after a period_end pulse, pwm_duty=0x40 and duty_pending=0. Without the macro, pwm_duty=0x40 right after WRITE.
- Sequencer writes 0x01←0xFF, then SPI writes 0x07←0x11 → each produces one wr_err pulse; all registers unchanged.
- Duty write of 0x90 in the WRITE cycle coincident with period_end, with 0x30 already pending → pwm_duty=0x30, shadow=0x90, duty_pending=1; next period_end gives pwm_duty=0x90.
- Assert rst during WRITE of 0x03←0x55 → pwm_en_hi=0x00, FSM in IDLE, both ready=0 next cycle.
